mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
- Multi-cycle control FSM for the RV32I core.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives the immediate-extender option, ALU operand selects, register-file/memory strobes and PC update.
- Handshakes with the instruction and data memories through req/ack pairs of variable latency.

Parameters:
- RESET_PC_HOLD, 0, cycles to hold in FETCH after reset deassert before the first imem_req (0..3).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ir_opcode  in  7  instruction[6:0], valid combinationally from IR.
- ir_funct3  in  3  instruction[14:12].
- alu_zero  in  1  ALU result == 0.
- alu_lt  in  1  signed rs1 < rs2.
- alu_ltu  in  1  unsigned rs1 < rs2.
- imem_ack  in  1  instruction word valid this cycle.
- dmem_ack  in  1  data access complete this cycle.
- imem_req  out  1  fetch request, held until ack.
- dmem_req  out  1  data request, held until ack.
- dmem_we  out  1  data write enable, qualifies dmem_req.
- ir_write  out  1  latch instruction into IR.
- imm_option  out  7  opcode-class code to the immediate extender (0 when not decoding).
- alu_a_sel  out  2  0 rs1, 1 PC, 2 zero.
- alu_b_sel  out  2  0 rs2, 1 imm, 2 const 4.
- alu_funct_en  out  1  1: ALU uses funct3/funct7; 0: ALU adds.
- reg_write  out  1  register-file write strobe.
- wb_sel  out  2  0 ALU result, 1 memory data, 2 PC+4, 3 imm.
- pc_write  out  1  PC update strobe.
- pc_src  out  2  0 PC+4, 1 PC+imm, 2 ALU result with bit 0 cleared.
- illegal  out  1  sticky: unsupported opcode seen.
- state_dbg  out  3  current state encoding.

Behaviour:
- **Reset.** rst async → state FETCH, hold counter = RESET_PC_HOLD, latched opcode = 0, illegal = 0. All outputs 0; state_dbg = FETCH.
- **Outputs.** Moore outputs, decoded from the state register and the latched opcode. Opcode/funct3 are latched on the cycle ir_write = 1.
- **FETCH.**
  - imem_req = 1 once the hold counter reaches 0; stays high until imem_ack.
  - On imem_ack: ir_write = 1 that cycle, go to DECODE.
  - imem_ack while imem_req = 0 is ignored.
- **DECODE (1 cycle).**
  - imm_option = latched opcode.
  - lui → WB. Legal opcode → EXEC. Other opcode → TRAP.
- **EXEC (1 cycle).** imm_option held.
  - R: a = rs1, b = rs2, funct_en = 1.
  - I: a = rs1, b = imm, funct_en = 1.
  - L/S/jalr: a = rs1, b = imm, funct_en = 0.
  - auipc: a = PC, b = imm.
  - jal: no ALU use.
  - B: a = rs1, b = rs2; pc_write = 1 this cycle.
    - Taken → pc_src = 1; not taken → pc_src = 0.
    - Taken per funct3: 000 zero; 001 !zero; 100 lt; 101 !lt; 110 ltu; 111 !ltu; 010/011 → TRAP, no pc_write.
    - Next state FETCH.
  - L/S → MEM. All others → WB.
- **MEM.**
  - dmem_req = 1 until dmem_ack; dmem_we = 1 only for S.
  - On ack: L → WB; S → FETCH with pc_write = 1, pc_src = 0 in the ack cycle.
- **WB (1 cycle).** reg_write = 1, pc_write = 1.
  - R/I/auipc: wb_sel = 0, pc_src = 0.
  - L: wb_sel = 1, pc_src = 0.
  - jal: wb_sel = 2, pc_src = 1.
  - jalr: wb_sel = 2, pc_src = 2; ALU result is held in the ALU-out register from EXEC.
  - lui: wb_sel = 3, pc_src = 0.
  - Next state FETCH.
- **TRAP.** illegal = 1; all strobes 0; remains until rst.
- **Cycle counts with ack in the first request cycle:**
  - lui 3; branch 3; R/I/auipc/jal/jalr 4; store 4; load 5.
  - Each extra wait cycle on an ack adds exactly 1.
- **One write per instruction.** Exactly one pc_write pulse per instruction; at most one reg_write pulse; reg_write never asserts for B/S.
- **Reset mid-operation.** Any state → FETCH immediately. Outstanding req drops in the same cycle; a late ack after reset is ignored (req = 0).

Decomposition:
- **Shared constant header.** Holds the opcode-class codes used for imm_option (IType, SType, LType, BType, jalType, jalrType, luiType, auipcType, plus RType). It also holds the state encodings, pc_src/wb_sel/alu_sel codes and the branch funct3 codes.
- **Sub-module.** One: mc_branch_cond (combinational funct3 + flags → taken, illegal_funct3), instantiated in EXEC decode.

Test Plan:
- **Reset/first fetch.** rst high for 3 cycles, release, RESET_PC_HOLD = 2 → imem_req rises exactly 2 cycles after release. All outputs 0 during reset.
- **Arithmetic sequence.** addi 0x00500093 (ack 0 wait), then add 0x002081B3 (ack after 2 waits) → addi: ir_write@1, DECODE imm_option = IType, WB reg_write, 4 cycles total. add completes in 6 cycles, alu_b_sel = 0.
- **Branches.**
  - beq with alu_zero = 1 → EXEC pc_write = 1, pc_src = 1, 3 cycles, no reg_write.
  - bltu with alu_ltu = 0 → pc_src = 0.
  - funct3 = 010 → TRAP, illegal = 1, no further imem_req.
- **Memory.**
  - lw with dmem_ack after 3 waits → dmem_we = 0, wb_sel = 1, total 8 cycles.
  - sw with immediate ack → dmem_we = 1, pc_write in ack cycle, no reg_write, 4 cycles.
- **Jumps/upper.**
  - jal → wb_sel = 2, pc_src = 1, imm_option = jalType.
  - jalr → pc_src = 2.
  - lui → 3 cycles, wb_sel = 3, imm_option = luiType in DECODE.
- **Async reset mid-MEM.** Assert rst while dmem_req = 1 → dmem_req low within the same cycle, state_dbg = FETCH. A dmem_ack pulse during reset or next cycle causes no reg_write/pc_write.

Source files
------------

// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared encodings for the RV32I multi-cycle control FSM: opcode classes,
// state codes, datapath mux codes and branch funct3 values.
package mc_ctrl_fsm_pkg;

    // Opcode-class codes double as the imm_option value, so they equal the opcodes
    localparam logic [6:0] RType     = 7'b0110011;
    localparam logic [6:0] IType     = 7'b0010011;
    localparam logic [6:0] LType     = 7'b0000011;
    localparam logic [6:0] SType     = 7'b0100011;
    localparam logic [6:0] BType     = 7'b1100011;
    localparam logic [6:0] jalType   = 7'b1101111;
    localparam logic [6:0] jalrType  = 7'b1100111;
    localparam logic [6:0] luiType   = 7'b0110111;
    localparam logic [6:0] auipcType = 7'b0010111;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_TRAP   = 3'd5;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_ALU   = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    localparam logic [1:0] A_RS1  = 2'd0;
    localparam logic [1:0] A_PC   = 2'd1;
    localparam logic [1:0] A_ZERO = 2'd2;
    localparam logic [1:0] B_RS2  = 2'd0;
    localparam logic [1:0] B_IMM  = 2'd1;
    localparam logic [1:0] B_FOUR = 2'd2;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    function automatic logic is_legal_opcode(input logic [6:0] op);
        logic legal;
        case (op)
            RType, IType, LType, SType, BType,
            jalType, jalrType, luiType, auipcType: legal = 1'b1;
            default:                               legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/mc_branch_cond.sv
// Branch resolution: maps funct3 and the ALU compare flags to taken / unsupported.
module mc_branch_cond
    import mc_ctrl_fsm_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    output logic       taken,
    output logic       illegal_funct3
);

    // funct3 010/011 have no branch meaning and fall to the default arm
    always_comb begin
        taken          = 1'b0;
        illegal_funct3 = 1'b0;
        case (funct3)
            F3_BEQ:  taken = zero;
            F3_BNE:  taken = !zero;
            F3_BLT:  taken = lt;
            F3_BGE:  taken = !lt;
            F3_BLTU: taken = ltu;
            F3_BGEU: taken = !ltu;
            default: illegal_funct3 = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with
// req/ack memory handshakes and a sticky TRAP for unsupported encodings.
module mc_ctrl_fsm
    import mc_ctrl_fsm_pkg::*;
#(
    parameter int unsigned RESET_PC_HOLD = 32'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] ir_opcode,
    input  logic [2:0] ir_funct3,
    input  logic       alu_zero,
    input  logic       alu_lt,
    input  logic       alu_ltu,
    input  logic       imem_ack,
    input  logic       dmem_ack,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       ir_write,
    output logic [6:0] imm_option,
    output logic [1:0] alu_a_sel,
    output logic [1:0] alu_b_sel,
    output logic       alu_funct_en,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       illegal,
    output logic [2:0] state_dbg
);

    localparam logic [1:0] HOLD_INIT = RESET_PC_HOLD[1:0];

    logic [2:0] state_r;
    logic [2:0] state_nxt_s;
    logic [1:0] hold_r;
    logic [6:0] opcode_r;
    logic [2:0] funct3_r;
    logic       illegal_r;
    logic       fetch_req_s;
    logic       ir_write_s;
    logic       is_store_s;
    logic       taken_s;
    logic       bad_funct3_s;

    mc_branch_cond u_branch_cond (
        .funct3         (funct3_r),
        .zero           (alu_zero),
        .lt             (alu_lt),
        .ltu            (alu_ltu),
        .taken          (taken_s),
        .illegal_funct3 (bad_funct3_s)
    );

    // rst masks the fetch handshake so no request is visible while held in reset
    assign fetch_req_s = (state_r == ST_FETCH) && (hold_r == 2'd0) && !rst;
    assign ir_write_s  = fetch_req_s && imem_ack;
    assign is_store_s  = (opcode_r == SType);

    assign imem_req  = fetch_req_s;
    assign ir_write  = ir_write_s;
    assign illegal   = illegal_r;
    assign state_dbg = state_r;

    // Next-state selection
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_FETCH: begin
                state_nxt_s = ir_write_s ? ST_DECODE : ST_FETCH;
            end
            ST_DECODE: begin
                if (opcode_r == luiType) begin
                    state_nxt_s = ST_WB;
                end else if (is_legal_opcode(opcode_r)) begin
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_TRAP;
                end
            end
            ST_EXEC: begin
                if (opcode_r == BType) begin
                    state_nxt_s = bad_funct3_s ? ST_TRAP : ST_FETCH;
                end else if ((opcode_r == LType) || is_store_s) begin
                    state_nxt_s = ST_MEM;
                end else begin
                    state_nxt_s = ST_WB;
                end
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    state_nxt_s = is_store_s ? ST_FETCH : ST_WB;
                end else begin
                    state_nxt_s = ST_MEM;
                end
            end
            ST_WB:   state_nxt_s = ST_FETCH;
            ST_TRAP: state_nxt_s = ST_TRAP;
            default: state_nxt_s = ST_FETCH;
        endcase
    end

    // State, post-reset fetch hold, latched instruction fields and sticky illegal flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_FETCH;
            hold_r    <= HOLD_INIT;
            opcode_r  <= 7'd0;
            funct3_r  <= 3'd0;
            illegal_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == ST_FETCH) && (hold_r != 2'd0)) begin
                hold_r <= hold_r - 2'd1;
            end
            if (ir_write_s) begin
                opcode_r <= ir_opcode;
                funct3_r <= ir_funct3;
            end
            if (state_nxt_s == ST_TRAP) begin
                illegal_r <= 1'b1;
            end
        end
    end

    // Datapath controls decoded from state and latched opcode; ack-qualified strobes pass through
    always_comb begin
        imm_option   = 7'd0;
        alu_a_sel    = A_RS1;
        alu_b_sel    = B_RS2;
        alu_funct_en = 1'b0;
        reg_write    = 1'b0;
        wb_sel       = WB_ALU;
        pc_write     = 1'b0;
        pc_src       = PC_PLUS4;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        case (state_r)
            ST_DECODE: imm_option = opcode_r;
            ST_EXEC: begin
                imm_option = opcode_r;
                case (opcode_r)
                    RType: alu_funct_en = 1'b1;
                    IType: begin
                        alu_b_sel    = B_IMM;
                        alu_funct_en = 1'b1;
                    end
                    LType, SType, jalrType: alu_b_sel = B_IMM;
                    auipcType: begin
                        alu_a_sel = A_PC;
                        alu_b_sel = B_IMM;
                    end
                    BType: begin
                        pc_write = !bad_funct3_s;
                        pc_src   = taken_s ? PC_IMM : PC_PLUS4;
                    end
                    default: alu_funct_en = 1'b0;
                endcase
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store_s;
                pc_write = is_store_s && dmem_ack;
            end
            ST_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                case (opcode_r)
                    LType:    wb_sel = WB_MEM;
                    jalType: begin
                        wb_sel = WB_PC4;
                        pc_src = PC_IMM;
                    end
                    jalrType: begin
                        wb_sel = WB_PC4;
                        pc_src = PC_ALU;
                    end
                    luiType:  wb_sel = WB_IMM;
                    default:  wb_sel = WB_ALU;
                endcase
            end
            default: imm_option = 7'd0;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomized bench for mc_ctrl_fsm: a per-instruction cycle-trace model is
// built from the instruction class and ack waits, then compared every cycle.
module tb_mc_ctrl_fsm;
    import mc_ctrl_fsm_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] ir_opcode = 7'd0;
    logic [2:0] ir_funct3 = 3'd0;
    logic       alu_zero = 1'b0, alu_lt = 1'b0, alu_ltu = 1'b0;
    logic       imem_ack = 1'b0, dmem_ack = 1'b0;
    logic       imem_req, dmem_req, dmem_we, ir_write, alu_funct_en;
    logic       reg_write, pc_write, illegal;
    logic [6:0] imm_option;
    logic [1:0] alu_a_sel, alu_b_sel, wb_sel, pc_src;
    logic [2:0] state_dbg;

    always #5 clk = ~clk;

    mc_ctrl_fsm #(.RESET_PC_HOLD(2)) dut (
        .clk(clk), .rst(rst), .ir_opcode(ir_opcode), .ir_funct3(ir_funct3),
        .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_write(ir_write),
        .imm_option(imm_option), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
        .alu_funct_en(alu_funct_en), .reg_write(reg_write), .wb_sel(wb_sel),
        .pc_write(pc_write), .pc_src(pc_src), .illegal(illegal), .state_dbg(state_dbg)
    );

    typedef struct {
        logic       imem_ack, dmem_ack;
        logic       imem_req, ir_write, dmem_req, dmem_we, reg_write, pc_write, illegal;
        logic [2:0] st;
        logic       imm_chk;  logic [6:0] imm;
        logic       a_chk;    logic [1:0] a;
        logic       b_chk;    logic [1:0] b;
        logic       fen_chk;  logic       fen;
        logic       wb_chk;   logic [1:0] wb;
        logic       src_chk;  logic [1:0] src;
    } cyc_t;

    cyc_t exp_q[$];
    int   n_checks = 0;
    int   n_err = 0;
    int   last_len, last_pcw, last_rw;
    logic [6:0] legal_ops [9] = '{RType, IType, LType, SType, BType,
                                  jalType, jalrType, luiType, auipcType};

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, got, want);
        end
    endtask

    function automatic cyc_t blank(input logic [2:0] st);
        cyc_t c;
        c.imem_ack = 1'b0; c.dmem_ack = 1'b0;
        c.imem_req = 1'b0; c.ir_write = 1'b0; c.dmem_req = 1'b0; c.dmem_we = 1'b0;
        c.reg_write = 1'b0; c.pc_write = 1'b0; c.illegal = 1'b0;
        c.st = st;
        c.imm_chk = 1'b0; c.imm = 7'd0;
        c.a_chk = 1'b0;   c.a = 2'd0;
        c.b_chk = 1'b0;   c.b = 2'd0;
        c.fen_chk = 1'b0; c.fen = 1'b0;
        c.wb_chk = 1'b0;  c.wb = 2'd0;
        c.src_chk = 1'b0; c.src = 2'd0;
        return c;
    endfunction

    task automatic add_trap();
        cyc_t c;
        for (int i = 0; i < 4; i++) begin
            c = blank(ST_TRAP);
            c.illegal  = 1'b1;
            c.imem_ack = 1'($urandom_range(0, 1));
            c.dmem_ack = 1'($urandom_range(0, 1));
            c.imm_chk  = 1'b1;
            exp_q.push_back(c);
        end
    endtask

    // Expected cycle trace of one instruction, straight from the class rules
    task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic z,
                         input logic lt, input logic ltu, input int iw, input int dw);
        cyc_t c;
        logic bad, taken, is_b, is_ls;
        bad   = (f3[2:1] == 2'b01);
        taken = (f3[2] ? (f3[1] ? ltu : lt) : z) ^ f3[0];
        is_b  = (op == BType);
        is_ls = (op == LType) || (op == SType);
        for (int i = 0; i <= iw; i++) begin
            c = blank(ST_FETCH);
            c.imem_req = 1'b1; c.imem_ack = (i == iw); c.ir_write = (i == iw); c.imm_chk = 1'b1;
            exp_q.push_back(c);
        end
        c = blank(ST_DECODE); c.imm_chk = 1'b1; c.imm = op;
        exp_q.push_back(c);
        if (!(op inside {RType, IType, LType, SType, BType, jalType, jalrType, luiType, auipcType})) begin
            add_trap();
            return;
        end
        if (op != luiType) begin
            c = blank(ST_EXEC); c.imm_chk = 1'b1; c.imm = op;
            if (op inside {RType, IType, LType, SType, jalrType, BType}) begin c.a_chk = 1'b1; c.a = A_RS1; end
            if (op inside {RType, BType}) begin c.b_chk = 1'b1; c.b = B_RS2; end
            if (op inside {IType, LType, SType, jalrType}) begin c.b_chk = 1'b1; c.b = B_IMM; end
            if (op inside {RType, IType}) begin c.fen_chk = 1'b1; c.fen = 1'b1; end
            if (op inside {LType, SType, jalrType}) begin c.fen_chk = 1'b1; c.fen = 1'b0; end
            if (op == auipcType) begin
                c.a_chk = 1'b1; c.a = A_PC; c.b_chk = 1'b1; c.b = B_IMM; c.fen_chk = 1'b1; c.fen = 1'b0;
            end
            if (is_b) begin
                c.pc_write = !bad; c.src_chk = !bad; c.src = taken ? PC_IMM : PC_PLUS4;
            end
            exp_q.push_back(c);
            if (is_b) begin
                if (bad) add_trap();
                return;
            end
            if (is_ls) begin
                for (int i = 0; i <= dw; i++) begin
                    c = blank(ST_MEM);
                    c.dmem_req = 1'b1; c.dmem_we = (op == SType); c.dmem_ack = (i == dw);
                    if ((op == SType) && (i == dw)) begin
                        c.pc_write = 1'b1; c.src_chk = 1'b1; c.src = PC_PLUS4;
                    end
                    exp_q.push_back(c);
                end
                if (op == SType) return;
            end
        end
        c = blank(ST_WB);
        c.reg_write = 1'b1; c.pc_write = 1'b1; c.wb_chk = 1'b1; c.src_chk = 1'b1;
        c.wb  = (op == LType) ? WB_MEM : (op inside {jalType, jalrType}) ? WB_PC4 :
                (op == luiType) ? WB_IMM : WB_ALU;
        c.src = (op == jalType) ? PC_IMM : (op == jalrType) ? PC_ALU : PC_PLUS4;
        exp_q.push_back(c);
    endtask

    task automatic compare(input cyc_t e);
        logic       ok;
        logic [6:0] gs, es;
        gs = {imem_req, ir_write, dmem_req, dmem_we, reg_write, pc_write, illegal};
        es = {e.imem_req, e.ir_write, e.dmem_req, e.dmem_we, e.reg_write, e.pc_write, e.illegal};
        ok = (gs === es) && (state_dbg === e.st);
        if (e.imm_chk && (imm_option !== e.imm)) ok = 1'b0;
        if (e.a_chk && (alu_a_sel !== e.a)) ok = 1'b0;
        if (e.b_chk && (alu_b_sel !== e.b)) ok = 1'b0;
        if (e.fen_chk && (alu_funct_en !== e.fen)) ok = 1'b0;
        if (e.wb_chk && (wb_sel !== e.wb)) ok = 1'b0;
        if (e.src_chk && (pc_src !== e.src)) ok = 1'b0;
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL cycle t=%0t op=%b: strobes/state/imm/a/b/fen/wb/src got %b/%0d/%b/%0d/%0d/%b/%0d/%0d required %b/%0d/%b/%0d/%0d/%b/%0d/%0d",
                     $time, ir_opcode, gs, state_dbg, imm_option, alu_a_sel, alu_b_sel, alu_funct_en,
                     wb_sel, pc_src, es, e.st, e.imm, e.a, e.b, e.fen, e.wb, e.src);
        end
    endtask

    // Entered and left one time unit after a rising edge
    task automatic play(input int max);
        cyc_t e;
        int   cyc = 0;
        last_len = 0; last_pcw = 0; last_rw = 0;
        while ((exp_q.size() > 0) && (cyc < max)) begin
            e = exp_q.pop_front();
            imem_ack = e.imem_ack;
            dmem_ack = e.dmem_ack;
            cyc++;
            @(negedge clk);
            compare(e);
            if (pc_write === 1'b1) begin
                last_pcw++;
                if (last_len == 0) last_len = cyc;
            end
            if (reg_write === 1'b1) last_rw++;
            @(posedge clk); #1;
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                             input logic lt, input logic ltu, input int iw, input int dw);
        ir_opcode = op; ir_funct3 = f3; alu_zero = z; alu_lt = lt; alu_ltu = ltu;
        build(op, f3, z, lt, ltu, iw, dw);
        play(1000);
    endtask

    task automatic do_reset();
        int k;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            imem_ack = 1'($urandom_range(0, 1));
            dmem_ack = 1'b1;
            @(negedge clk);
            check_val("outputs idle in reset",
                      32'({imem_req, dmem_req, dmem_we, ir_write, imm_option, alu_a_sel, alu_b_sel,
                           alu_funct_en, reg_write, wb_sel, pc_write, pc_src, illegal}), 32'd0);
            check_val("state_dbg in reset", 32'(state_dbg), 32'(ST_FETCH));
            @(posedge clk); #1;
        end
        rst = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b1;
        k = 0;
        while (k < 8) begin
            @(negedge clk);
            check_val("no strobe during hold", 32'({reg_write, pc_write, dmem_req, ir_write}), 32'd0);
            if (imem_req === 1'b1) break;
            k++;
            @(posedge clk); #1;
            imem_ack = 1'b0; dmem_ack = 1'b0;
        end
        check_val("first imem_req delay", 32'(k), 32'd2);
        @(posedge clk); #1;
        imem_ack = 1'b0; dmem_ack = 1'b0;
    endtask

    task automatic random_run(input int n);
        logic [6:0] op;
        logic [2:0] f3;
        for (int i = 0; i < n; i++) begin
            op = legal_ops[$urandom_range(0, 8)];
            f3 = 3'($urandom_range(0, 7));
            if ((op == BType) && (f3[2:1] == 2'b01)) f3[2] = 1'b1;
            run_instr(op, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            check_val("pc_write pulses per instr", 32'(last_pcw), 32'd1);
            check_val("reg_write pulses per instr", 32'(last_rw),
                      (op inside {BType, SType}) ? 32'd0 : 32'd1);
        end
    endtask

    initial begin
        do_reset();
        run_instr(IType, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);
        check_val("addi cycles", 32'(last_len), 32'd4);
        run_instr(RType, 3'b000, 1'b0, 1'b1, 1'b0, 2, 0);
        check_val("add cycles", 32'(last_len), 32'd6);
        run_instr(BType, 3'b000, 1'b1, 1'b0, 1'b0, 0, 0);
        check_val("beq cycles", 32'(last_len), 32'd3);
        check_val("beq reg_write", 32'(last_rw), 32'd0);
        run_instr(BType, 3'b110, 1'b0, 1'b1, 1'b0, 0, 0);
        check_val("bltu cycles", 32'(last_len), 32'd3);
        run_instr(LType, 3'b010, 1'b0, 1'b0, 1'b0, 0, 3);
        check_val("lw cycles", 32'(last_len), 32'd8);
        run_instr(SType, 3'b010, 1'b0, 1'b0, 1'b0, 0, 0);
        check_val("sw cycles", 32'(last_len), 32'd4);
        check_val("sw reg_write", 32'(last_rw), 32'd0);
        run_instr(jalType, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);
        check_val("jal cycles", 32'(last_len), 32'd4);
        run_instr(jalrType, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);
        check_val("jalr cycles", 32'(last_len), 32'd4);
        run_instr(luiType, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);
        check_val("lui cycles", 32'(last_len), 32'd3);

        random_run(80);

        // Reset while a load waits in MEM
        ir_opcode = LType; ir_funct3 = 3'b010;
        build(LType, 3'b010, 1'b0, 1'b0, 1'b0, 0, 5);
        play(4);
        check_val("dmem_req before rst", 32'(dmem_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_val("dmem_req drops with rst", 32'(dmem_req), 32'd0);
        check_val("state_dbg FETCH on rst", 32'(state_dbg), 32'(ST_FETCH));
        check_val("no writes on rst", 32'({reg_write, pc_write}), 32'd0);
        exp_q.delete();
        do_reset();

        random_run(20);

        run_instr(BType, 3'b010, 1'b1, 1'b1, 1'b1, 1, 0);
        check_val("bad funct3 illegal", 32'(illegal), 32'd1);
        check_val("bad funct3 pc_write", 32'(last_pcw), 32'd0);
        do_reset();
        check_val("illegal cleared by rst", 32'(illegal), 32'd0);
        run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);
        check_val("bad opcode illegal", 32'(illegal), 32'd1);
        do_reset();
        random_run(10);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
